// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the default geometry and timing constants.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MIN_ACCESS = 2;
   localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data_mem port seen by the arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface data_mem_arbiter_if
   import data_mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              r0_req;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_memwrite;
   logic              r0_memread;
   logic [3:0]        r0_sign_mask;
   logic [DATA_W-1:0] r0_rdata;
   logic              r0_ack;
   logic              r0_stall;

   logic              r1_req;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_memwrite;
   logic              r1_memread;
   logic [3:0]        r1_sign_mask;
   logic [DATA_W-1:0] r1_rdata;
   logic              r1_ack;
   logic              r1_stall;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_memwrite;
   logic              mem_memread;
   logic [3:0]        mem_sign_mask;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_clk_stall;

   logic              timeout_err;

   modport slave (
      input  r0_req, r0_addr, r0_wdata, r0_memwrite, r0_memread, r0_sign_mask,
      output r0_rdata, r0_ack, r0_stall,
      input  r1_req, r1_addr, r1_wdata, r1_memwrite, r1_memread, r1_sign_mask,
      output r1_rdata, r1_ack, r1_stall,
      output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
      input  mem_read_data, mem_clk_stall,
      output timeout_err
   );

   modport master (
      output r0_req, r0_addr, r0_wdata, r0_memwrite, r0_memread, r0_sign_mask,
      input  r0_rdata, r0_ack, r0_stall,
      output r1_req, r1_addr, r1_wdata, r1_memwrite, r1_memread, r1_sign_mask,
      input  r1_rdata, r1_ack, r1_stall,
      input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
      output mem_read_data, mem_clk_stall,
      input  timeout_err
   );

endinterface

// File: rtl/arb_rr2.sv
// Two-input winner picker. Round-robin by default; with ARB_FIXED_PRIO_EN
// defined r0 always wins and no pointer register exists.
module arb_rr2
   import data_mem_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic winner
);

`ifdef ARB_FIXED_PRIO_EN
   logic unused_inputs;

   assign unused_inputs = &{1'b0, clk, reset, req1, advance};
   assign winner        = ~req0;
`else
   logic favour_r1;

   // On contention the requester not granted last wins; a lone request always wins.
   assign winner = req1 & (~req0 | favour_r1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         favour_r1 <= 1'b0;
      end else if (advance) begin
         favour_r1 <= ~winner;
      end
   end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data_mem port between two requesters (IDLE/ACCESS/ACK FSM).
// ARB_FIXED_PRIO_EN switches the picker from round-robin to fixed r0 priority.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MIN_ACCESS = DEF_MIN_ACCESS,
   parameter int TIMEOUT    = DEF_TIMEOUT
)(
   input logic               clk,
   input logic               reset,
   data_mem_arbiter_if.slave bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_ACCESS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   arb_state_t        state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic              owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q, re_q;
   logic [3:0]        mask_q;
   logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
   logic              timeout_q;

   logic              winner, grant, access_done, access_abort;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we, sel_re;
   logic [3:0]        sel_mask;
   logic              capture, cap_sel;
   logic [DATA_W-1:0] cap_data;

   arb_rr2 u_pick (
      .clk     (clk),
      .reset   (reset),
      .req0    (bus.r0_req),
      .req1    (bus.r1_req),
      .advance (grant),
      .winner  (winner)
   );

   assign sel_addr  = winner ? bus.r1_addr      : bus.r0_addr;
   assign sel_wdata = winner ? bus.r1_wdata     : bus.r0_wdata;
   assign sel_we    = winner ? bus.r1_memwrite  : bus.r0_memwrite;
   assign sel_re    = winner ? bus.r1_memread   : bus.r0_memread;
   assign sel_mask  = winner ? bus.r1_sign_mask : bus.r0_sign_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // cnt holds completed ACCESS cycles, so the exit test lands one cycle after
   // MIN_ACCESS cycles and an abort happens at the end of the TIMEOUT-th cycle.
   always_comb begin
      next_state   = state;
      grant        = 1'b0;
      access_done  = 1'b0;
      access_abort = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.r0_req || bus.r1_req) begin
               grant      = 1'b1;
               next_state = (sel_we || sel_re) ? ACCESS : ACK;
            end
         end
         ACCESS: begin
            if (cnt >= MIN_CNT && !bus.mem_clk_stall) begin
               access_done = 1'b1;
               next_state  = ACK;
            end else if (cnt == LAST_CNT) begin
               access_abort = 1'b1;
               next_state   = ACK;
            end
         end
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign cap_sel  = grant ? winner : owner;
   assign capture  = access_done | access_abort | (grant & ~(sel_we | sel_re));
   assign cap_data = access_done ? bus.mem_read_data : (access_abort ? '1 : '0);

   // Request latch, access counter, per-requester read data and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         owner      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         mask_q     <= '0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (grant) begin
            cnt     <= '0;
            owner   <= winner;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            re_q    <= sel_re;
            mask_q  <= sel_mask;
         end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
         end
         if (capture) begin
            if (cap_sel) r1_rdata_q <= cap_data;
            else         r0_rdata_q <= cap_data;
         end
         if (access_abort) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.mem_addr       = addr_q;
   assign bus.mem_write_data = wdata_q;
   assign bus.mem_sign_mask  = mask_q;
   assign bus.mem_memwrite   = (state == ACCESS) & we_q;
   assign bus.mem_memread    = (state == ACCESS) & re_q & ~we_q;

   assign bus.r0_ack      = (state == ACK) & ~owner;
   assign bus.r1_ack      = (state == ACK) & owner;
   assign bus.r0_stall    = bus.r0_req & ~bus.r0_ack;
   assign bus.r1_stall    = bus.r1_req & ~bus.r1_ack;
   assign bus.r0_rdata    = r0_rdata_q;
   assign bus.r1_rdata    = r1_rdata_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter (MIN_ACCESS=2, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MIN_ACCESS (2),
      .TIMEOUT    (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic idle_inputs();
      bus.r0_req = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r0_memwrite = 0; bus.r0_memread = 0; bus.r0_sign_mask = 4'h0;
      bus.r1_req = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
      bus.r1_memwrite = 0; bus.r1_memread = 0; bus.r1_sign_mask = 4'h0;
      bus.mem_read_data = '0; bus.mem_clk_stall = 0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ack(input bit who, input int budget, output int n);
      int  k;
      bit  hit;
      k   = 0;
      hit = 0;
      while (!hit && k < budget) begin
         @(negedge clk);
         k++;
         hit = who ? (bus.r1_ack === 1'b1) : (bus.r0_ack === 1'b1);
      end
      n = hit ? k : -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      checks++; if (bus.r0_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_r0_ack got %b want 0", bus.r0_ack); end
      checks++; if (bus.r1_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_r1_ack got %b want 0", bus.r1_ack); end
      checks++; if ({bus.mem_memwrite, bus.mem_memread} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got %b want 00", {bus.mem_memwrite, bus.mem_memread}); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got %b want 0", bus.timeout_err); end
      checks++; if (bus.r0_rdata !== 32'h0 || bus.r1_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h/%h want 0/0", bus.r0_rdata, bus.r1_rdata); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      int lat;
      bus.r0_req = 1; bus.r0_addr = 32'h100; bus.r0_memread = 1; bus.r0_sign_mask = 4'hF;
      bus.mem_read_data = 32'hDEADBEEF;
      lat = -1;
      for (int n = 1; n <= 12 && lat < 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++; if (bus.mem_memread !== 1'b1 || bus.mem_memwrite !== 1'b0) begin errors++; $display("[TB] FAIL read_strobes got rd=%b wr=%b want rd=1 wr=0", bus.mem_memread, bus.mem_memwrite); end
            checks++; if (bus.mem_addr !== 32'h100 || bus.mem_sign_mask !== 4'hF) begin errors++; $display("[TB] FAIL read_addr got %h mask %h want 00000100 mask f", bus.mem_addr, bus.mem_sign_mask); end
            checks++; if (bus.r0_stall !== 1'b1) begin errors++; $display("[TB] FAIL read_stall got %b want 1", bus.r0_stall); end
         end
         if (bus.r0_ack === 1'b1) lat = n;
      end
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL read_latency got %0d want 4", lat); end
      checks++; if (bus.r0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata got %h want deadbeef", bus.r0_rdata); end
      checks++; if (bus.r0_stall !== 1'b0) begin errors++; $display("[TB] FAIL read_stall_at_ack got %b want 0", bus.r0_stall); end
      bus.r0_req = 0; bus.r0_memread = 0; bus.mem_read_data = '0;
      @(negedge clk);
      checks++; if (bus.r0_ack !== 1'b0) begin errors++; $display("[TB] FAIL read_ack_width got %b want 0", bus.r0_ack); end
      checks++; if (bus.r0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata_hold got %h want deadbeef", bus.r0_rdata); end
   endtask

   task automatic test_round_robin();
      bit exp_who [4];
      int k;
      bit got_who;
      bit hit;
`ifdef ARB_FIXED_PRIO_EN
      exp_who = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      pulse_reset();
      bus.r0_req = 1; bus.r0_addr = 32'h10; bus.r0_memread = 1;
      bus.r1_req = 1; bus.r1_addr = 32'h20; bus.r1_memread = 1;
      bus.mem_read_data = 32'h11111111;
      for (int g = 0; g < 4; g++) begin
         k   = 0;
         hit = 0;
         got_who = 0;
         while (!hit && k < 12) begin
            @(negedge clk);
            k++;
            if (bus.r0_ack === 1'b1 && bus.r1_ack === 1'b1) begin
               checks++; errors++; $display("[TB] FAIL rr_dual_ack got 11 want one-hot");
            end
            if (bus.r0_ack === 1'b1) begin hit = 1; got_who = 0; end
            else if (bus.r1_ack === 1'b1) begin hit = 1; got_who = 1; end
         end
         checks++; if (!hit || got_who !== exp_who[g]) begin errors++; $display("[TB] FAIL rr_order_%0d got r%0d (hit=%0d) want r%0d", g, got_who, hit, exp_who[g]); end
         checks++; if (k != ((g == 0) ? 4 : 5)) begin errors++; $display("[TB] FAIL rr_latency_%0d got %0d want %0d", g, k, (g == 0) ? 4 : 5); end
         if (g == 0) begin
            checks++; if (bus.r1_stall !== 1'b1) begin errors++; $display("[TB] FAIL rr_loser_stall got %b want 1", bus.r1_stall); end
         end
      end
      bus.r0_req = 0; bus.r0_memread = 0;
      bus.r1_req = 0; bus.r1_memread = 0;
      @(negedge clk);
   endtask

   task automatic test_write_stall();
      int lat;
      int wcnt;
      bus.r1_req = 1; bus.r1_addr = 32'h2000; bus.r1_wdata = 32'h12345678;
      bus.r1_memwrite = 1; bus.r1_memread = 1; bus.r1_sign_mask = 4'h3;
      bus.mem_read_data = 32'h5555AAAA; bus.mem_clk_stall = 1;
      lat  = -1;
      wcnt = 0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.mem_memwrite === 1'b1) wcnt++;
         if (n == 1) begin
            checks++; if (bus.mem_memread !== 1'b0) begin errors++; $display("[TB] FAIL wr_read_suppressed got %b want 0", bus.mem_memread); end
            checks++; if (bus.mem_addr !== 32'h2000 || bus.mem_write_data !== 32'h12345678) begin errors++; $display("[TB] FAIL wr_bus got %h/%h want 00002000/12345678", bus.mem_addr, bus.mem_write_data); end
         end
         if (bus.r1_ack === 1'b1) lat = n;
         if (n == 5) bus.mem_clk_stall = 0;
      end
      checks++; if (wcnt != 5) begin errors++; $display("[TB] FAIL wr_strobe_cycles got %0d want 5", wcnt); end
      checks++; if (lat != 6) begin errors++; $display("[TB] FAIL wr_ack_latency got %0d want 6", lat); end
      checks++; if (bus.r1_rdata !== 32'h5555AAAA) begin errors++; $display("[TB] FAIL wr_rdata got %h want 5555aaaa", bus.r1_rdata); end
      bus.r1_req = 0; bus.r1_memwrite = 0; bus.r1_memread = 0; bus.mem_clk_stall = 0;
      @(negedge clk);
   endtask

   task automatic test_bypass();
      int lat;
      int scnt;
      bus.r1_req = 1; bus.r1_addr = 32'h44;
      lat  = -1;
      scnt = 0;
      for (int n = 1; n <= 8 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.mem_memwrite === 1'b1 || bus.mem_memread === 1'b1) scnt++;
         if (bus.r1_ack === 1'b1) lat = n;
      end
      checks++; if (lat != 1) begin errors++; $display("[TB] FAIL bypass_latency got %0d want 1", lat); end
      checks++; if (scnt != 0) begin errors++; $display("[TB] FAIL bypass_strobes got %0d want 0", scnt); end
      checks++; if (bus.r1_rdata !== 32'h0) begin errors++; $display("[TB] FAIL bypass_rdata got %h want 0", bus.r1_rdata); end
      bus.r1_req = 0;
      @(negedge clk);
   endtask

   task automatic test_drop_req();
      int n;
      bus.r0_req = 1; bus.r0_addr = 32'h80; bus.r0_memread = 1;
      bus.mem_read_data = 32'h0BADF00D;
      @(negedge clk);
      bus.r0_req = 0; bus.r0_memread = 0;
      wait_ack(1'b0, 12, n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL drop_ack_latency got %0d want 3", n); end
      checks++; if (bus.r0_rdata !== 32'h0BADF00D || bus.r0_stall !== 1'b0) begin errors++; $display("[TB] FAIL drop_rdata got %h stall %b want 0badf00d stall 0", bus.r0_rdata, bus.r0_stall); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int lat;
      int rcnt;
      bus.r0_req = 1; bus.r0_addr = 32'h300; bus.r0_memread = 1;
      bus.mem_read_data = 32'h12121212; bus.mem_clk_stall = 1;
      lat  = -1;
      rcnt = 0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.mem_memread === 1'b1) rcnt++;
         if (n == 1) begin
            checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_early got %b want 0", bus.timeout_err); end
         end
         if (bus.r0_ack === 1'b1) lat = n;
      end
      checks++; if (rcnt != 8) begin errors++; $display("[TB] FAIL to_strobe_cycles got %0d want 8", rcnt); end
      checks++; if (lat != 9) begin errors++; $display("[TB] FAIL to_ack_latency got %0d want 9", lat); end
      checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set got %b want 1", bus.timeout_err); end
      checks++; if (bus.r0_rdata !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL to_rdata got %h want ffffffff", bus.r0_rdata); end
      bus.r0_req = 0; bus.r0_memread = 0; bus.mem_clk_stall = 0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_sticky got %b want 1", bus.timeout_err); end
   endtask

   task automatic test_reset_mid_access();
      int acks;
      int n;
      bus.r0_req = 1; bus.r0_addr = 32'h40; bus.r0_memread = 1;
      bus.mem_read_data = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.mem_memread !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_access got %b want 1", bus.mem_memread); end
      reset = 1'b1;
      #1;
      checks++; if (bus.mem_memread !== 1'b0 || bus.r0_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs got rd=%b ack=%b want 0/0", bus.mem_memread, bus.r0_ack); end
      checks++; if (bus.timeout_err !== 1'b0 || bus.r0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_clear got err=%b rdata=%h want 0/0", bus.timeout_err, bus.r0_rdata); end
      bus.r0_req = 0; bus.r0_memread = 0;
      @(negedge clk);
      reset = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.r0_ack === 1'b1 || bus.r1_ack === 1'b1) acks++;
      end
      checks++; if (acks != 0) begin errors++; $display("[TB] FAIL rst_mid_no_ack got %0d want 0", acks); end
      bus.r0_req = 1; bus.r0_memread = 1;
      wait_ack(1'b0, 12, n);
      checks++; if (n != 4 || bus.r0_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rst_mid_recover got lat=%0d rdata=%h want 4/cafef00d", n, bus.r0_rdata); end
      bus.r0_req = 0; bus.r0_memread = 0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_read();
      test_round_robin();
      test_write_stall();
      test_bypass();
      test_drop_req();
      test_timeout();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MIN_ACCESS, default 2, minimum cycles in ACCESS.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles in ACCESS before abort.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports r0_req/r1_req, input, 1, requester n asks for an access.
REQ-008 SHALL have ports rN_addr, input, ADDR_W; rN_wdata, input, DATA_W; rN_memwrite, rN_memread, input, 1; rN_sign_mask, input, 4.
REQ-009 SHALL have ports rN_rdata, output, DATA_W, read data; rN_ack, output, 1, one-cycle completion pulse; rN_stall, output, 1, equal to rN_req AND NOT rN_ack.
REQ-010 SHALL have ports mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask, outputs, toward data_mem; mem_read_data, input, DATA_W; mem_clk_stall, input, 1.
REQ-011 SHALL have port timeout_err, output, 1, sticky abort flag.

Function
REQ-012 SHALL implement states IDLE, ACCESS, ACK.
REQ-013 IDLE: if any rN_req, SHALL latch winner's addr/wdata/memwrite/memread/sign_mask into registers, go to ACCESS; else stay.
REQ-014 Both requests in the same IDLE cycle SHALL be resolved round-robin: winner is the requester not granted last; pointer updates on every grant; pointer resets to favour r0.
REQ-015 mem_* outputs SHALL be driven only from latched registers; strobes SHALL be 0 outside ACCESS.
REQ-016 If latched memread and memwrite are both 1, SHALL drive memwrite only.
REQ-017 If both latched strobes are 0, SHALL bypass ACCESS: IDLE -> ACK, rdata zero.
REQ-018 ACCESS SHALL count cycles from 1; exit to ACK when count >= MIN_ACCESS and mem_clk_stall is 0, capturing mem_read_data into the winner's rdata register.
REQ-019 If count reaches TIMEOUT, SHALL drop strobes, set timeout_err, go to ACK with rdata all ones.
REQ-020 ACK SHALL pulse winner's rN_ack for exactly one cycle, then return to IDLE; a new grant is never issued in the ACK cycle.
REQ-021 Minimum latency: req sampled at edge k, ack high in cycle after edge k+MIN_ACCESS+1.
REQ-022 rN_rdata SHALL hold its value until that requester's next ack.
REQ-023 A request deasserted mid-access SHALL NOT abort it; ack still pulses and is ignored.
REQ-024 timeout_err SHALL clear only on reset.

Reset
REQ-025 reset SHALL immediately force state IDLE, all strobes, acks, timeout_err, counter, rdata registers to 0, pointer to r0.
REQ-026 Reset mid-ACCESS SHALL abandon the access with no ack.

Configuration
REQ-027 With ARB_FIXED_PRIO_EN defined, r0 SHALL always win simultaneous requests and the pointer SHALL be omitted; without it, REQ-014 round-robin applies.

Structure
REQ-028 State encoding and default parameter constants SHALL reside in shared package data_mem_arb_pkg.
REQ-029 Winner selection SHALL be sub-module arb_rr2 (two-input round-robin picker, combinational plus pointer register).

Verification
REQ-030 r0 read addr 0x100, mem_read_data 0xDEADBEEF, mem_clk_stall low: r0_ack at cycle 4, r0_rdata 0xDEADBEEF.
REQ-031 r0 and r1 both request after reset: r0 served first, r1 next; repeat: r1 first (fixed-prio build: r0 both times).
REQ-032 r1 write 0x12345678 to 0x2000, mem_clk_stall high 5 cycles: mem_memwrite held 5+ cycles, r1_ack after stall drops.
REQ-033 mem_clk_stall stuck high, TIMEOUT=8: strobes drop after 8 cycles, timeout_err 1, r0_rdata 0xFFFFFFFF.
REQ-034 reset asserted in ACCESS: outputs 0 same cycle, no ack, next request served normally.
